// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache to memory-port arbiter.
// The line and address widths match the caches and the cacheline adaptor.
package cache_mem_arbiter_pkg;

  localparam int ADDR_W   = 32;
  localparam int LINE_W   = 256;
  localparam int MAX_SKIP = 4;

  // Byte offset within a 32-byte (256-bit) cacheline.
  localparam int OFFSET_W = 5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    I_READ  = 3'd1,
    D_READ  = 3'd2,
    D_WRITE = 3'd3,
    DONE    = 3'd4
  } arb_state_t;

  // A dcache grant becomes a writeback whenever d_write is set, so a dirty
  // victim always leaves before its replacement line is fetched.
  function automatic arb_state_t dcache_state(input logic d_write);
    return d_write ? D_WRITE : D_READ;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares one cacheline memory port between the icache and the dcache.
// The dcache has fixed priority, but after MAX_SKIP back-to-back dcache
// grants made while the icache waits, the icache is served next. One line
// transaction is in flight at a time, followed by a single bubble cycle.
module cache_mem_arbiter #(
  parameter int ADDR_W   = cache_mem_arbiter_pkg::ADDR_W,
  parameter int LINE_W   = cache_mem_arbiter_pkg::LINE_W,
  parameter int MAX_SKIP = cache_mem_arbiter_pkg::MAX_SKIP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              arb_conflict
);

  import cache_mem_arbiter_pkg::*;

  // Counter range is 0..MAX_SKIP inclusive.
  localparam int                SKIP_W     = $clog2(MAX_SKIP + 1);
  localparam logic [SKIP_W-1:0] SKIP_LIMIT = SKIP_W'(MAX_SKIP);
  localparam logic [SKIP_W-1:0] SKIP_ONE   = SKIP_W'(1);
  localparam logic [SKIP_W-1:0] SKIP_ZERO  = {SKIP_W{1'b0}};

  arb_state_t        state_q;
  logic [SKIP_W-1:0] skip_q;
  logic [SKIP_W-1:0] skip_d;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_address_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic [LINE_W-1:0] i_rdata_q;
  logic [LINE_W-1:0] d_rdata_q;
  logic              i_resp_q;
  logic              d_resp_q;
  logic              arb_conflict_q;

  logic              d_req_s;
  logic              both_req_s;
  logic              grant_i_s;
  logic              grant_d_s;

  // The adaptor always transfers whole lines, so the byte offset is dropped.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
  endfunction

  // Grant decision and anti-starvation counter update, evaluated only in IDLE.
  always_comb begin
    d_req_s    = d_read | d_write;
    both_req_s = i_read & d_req_s;
    grant_i_s  = 1'b0;
    grant_d_s  = 1'b0;
    skip_d     = skip_q;
    if (state_q == IDLE) begin
      if (both_req_s) begin
        if (skip_q < SKIP_LIMIT) begin
          grant_d_s = 1'b1;
          skip_d    = skip_q + SKIP_ONE;
        end else begin
          grant_i_s = 1'b1;
          skip_d    = SKIP_ZERO;
        end
      end else if (i_read) begin
        grant_i_s = 1'b1;
        skip_d    = SKIP_ZERO;
      end else begin
        // With no icache request there is nobody to starve.
        grant_d_s = d_req_s;
        skip_d    = SKIP_ZERO;
      end
    end else begin
      skip_d = skip_q;
    end
  end

  // Transaction FSM with registered memory-side requests and cache responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      skip_q         <= SKIP_ZERO;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_address_q  <= {ADDR_W{1'b0}};
      mem_wdata_q    <= {LINE_W{1'b0}};
      i_rdata_q      <= {LINE_W{1'b0}};
      d_rdata_q      <= {LINE_W{1'b0}};
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      arb_conflict_q <= 1'b0;
    end else begin
      // Responses and the conflict flag are single-cycle pulses.
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      arb_conflict_q <= 1'b0;
      skip_q         <= skip_d;
      case (state_q)
        IDLE: begin
          if (grant_i_s) begin
            state_q        <= I_READ;
            mem_read_q     <= 1'b1;
            mem_write_q    <= 1'b0;
            mem_address_q  <= line_align(i_address);
            arb_conflict_q <= both_req_s;
          end else if (grant_d_s) begin
            state_q        <= dcache_state(d_write);
            mem_read_q     <= ~d_write;
            mem_write_q    <= d_write;
            mem_address_q  <= line_align(d_address);
            mem_wdata_q    <= d_wdata;
            arb_conflict_q <= both_req_s;
          end else begin
            state_q <= IDLE;
          end
        end
        I_READ: begin
          if (mem_resp) begin
            state_q    <= DONE;
            mem_read_q <= 1'b0;
            i_rdata_q  <= mem_rdata;
            i_resp_q   <= 1'b1;
          end else begin
            state_q <= I_READ;
          end
        end
        D_READ: begin
          if (mem_resp) begin
            state_q    <= DONE;
            mem_read_q <= 1'b0;
            d_rdata_q  <= mem_rdata;
            d_resp_q   <= 1'b1;
          end else begin
            state_q <= D_READ;
          end
        end
        D_WRITE: begin
          if (mem_resp) begin
            state_q     <= DONE;
            mem_write_q <= 1'b0;
            d_resp_q    <= 1'b1;
          end else begin
            state_q <= D_WRITE;
          end
        end
        DONE: begin
          // Bubble cycle lets the served cache drop its request first.
          state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_read     = mem_read_q;
  assign mem_write    = mem_write_q;
  assign mem_address  = mem_address_q;
  assign mem_wdata    = mem_wdata_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign arb_conflict = arb_conflict_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench for cache_mem_arbiter: directed scenarios followed by
// random transaction rounds, checked against a transaction-level model.
module tb_cache_mem_arbiter;

  localparam int AW   = 32;
  localparam int LW   = 256;
  localparam int MAXS = 4;

  logic          clk;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;
  logic          arb_conflict;

  int checks;
  int errors;

  // Transaction-level model state: outstanding requests, skip count, last lines.
  logic          i_pend;
  logic [AW-1:0] i_addr_m;
  logic          d_pend;
  logic          d_rd_m;
  logic          d_wr_m;
  logic [AW-1:0] d_addr_m;
  logic [LW-1:0] d_wd_m;
  int            skip_m;
  logic [LW-1:0] i_last;
  logic [LW-1:0] d_last;

  cache_mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .arb_conflict (arb_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return (a / 32'd32) * 32'd32;
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chka(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkl(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag);
    chk1({tag, "_mem_read"}, mem_read, 1'b0);
    chk1({tag, "_mem_write"}, mem_write, 1'b0);
    chk1({tag, "_i_resp"}, i_resp, 1'b0);
    chk1({tag, "_d_resp"}, d_resp, 1'b0);
  endtask

  task automatic model_reset();
    i_pend = 1'b0; d_pend = 1'b0; d_rd_m = 1'b0; d_wr_m = 1'b0;
    skip_m = 0; i_last = '0; d_last = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  // One full transaction. Entered and left on a falling edge with the arbiter idle.
  task automatic round(input bit new_i, input logic [AW-1:0] ia,
                       input bit new_d, input bit dr, input bit dw,
                       input logic [AW-1:0] da, input logic [LW-1:0] wd,
                       input int lat, input logic [LW-1:0] rd, output bit won_i);
    bit both;
    bit wi;
    bit wwr;
    logic [AW-1:0] exp_addr;
    quiet("pre");
    if (new_i && !i_pend) begin
      i_pend = 1'b1; i_addr_m = ia; i_read = 1'b1; i_address = ia;
    end
    if (new_d && !d_pend) begin
      d_pend = 1'b1; d_rd_m = dr; d_wr_m = dw; d_addr_m = da; d_wd_m = wd;
      d_read = dr; d_write = dw; d_address = da; d_wdata = wd;
    end
    both = i_pend && d_pend;
    if (both) begin
      if (skip_m < MAXS) begin wi = 1'b0; skip_m++; end
      else begin wi = 1'b1; skip_m = 0; end
    end else begin
      wi = i_pend; skip_m = 0;
    end
    wwr = !wi && d_wr_m;
    exp_addr = wi ? line_of(i_addr_m) : line_of(d_addr_m);
    @(negedge clk);
    chk1("grant_rd", mem_read, !wwr);
    chk1("grant_wr", mem_write, wwr);
    chka("grant_addr", mem_address, exp_addr);
    chk1("grant_conflict", arb_conflict, both);
    if (wwr) chkl("grant_wdata", mem_wdata, d_wd_m);
    // The winner's inputs change after grant; the transaction must not notice.
    if (wi) i_address = $urandom;
    else begin d_address = $urandom; d_wdata = rand_line(); end
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk1("hold_rd", mem_read, !wwr);
      chk1("hold_wr", mem_write, wwr);
      chka("hold_addr", mem_address, exp_addr);
      chk1("hold_conflict", arb_conflict, 1'b0);
      chk1("hold_i_resp", i_resp, 1'b0);
      chk1("hold_d_resp", d_resp, 1'b0);
      if (wwr) chkl("hold_wdata", mem_wdata, d_wd_m);
    end
    mem_resp = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_resp = 1'b0; mem_rdata = rand_line();
    if (wi) i_last = rd;
    else if (!wwr) d_last = rd;
    chk1("resp_i", i_resp, wi);
    chk1("resp_d", d_resp, !wi);
    chkl("resp_i_rdata", i_rdata, i_last);
    chkl("resp_d_rdata", d_rdata, d_last);
    chk1("resp_mem_read", mem_read, 1'b0);
    chk1("resp_mem_write", mem_write, 1'b0);
    chk1("resp_conflict", arb_conflict, 1'b0);
    won_i = i_resp;
    if (wi) begin
      i_read = 1'b0; i_pend = 1'b0;
    end else if (wwr && d_rd_m) begin
      // Writeback done; the fill of the same line is still wanted.
      d_write = 1'b0; d_wr_m = 1'b0; d_address = d_addr_m; d_wdata = d_wd_m;
    end else begin
      d_read = 1'b0; d_write = 1'b0; d_pend = 1'b0;
    end
    @(negedge clk);
  endtask

  // Idle cycles with no requests; a stray mem_resp must be ignored.
  task automatic idle_with_resp(input int n);
    skip_m = 0;
    mem_resp = 1'b1; mem_rdata = rand_line();
    @(negedge clk);
    mem_resp = 1'b0;
    quiet("stray");
    chkl("stray_i_rdata", i_rdata, i_last);
    chkl("stray_d_rdata", d_rdata, d_last);
    repeat (n) begin
      @(negedge clk);
      quiet("idle");
    end
  endtask

  initial begin
    bit won;
    bit ni;
    bit nd;
    int kind;
    logic [AW-1:0] seq;
    checks = 0; errors = 0;
    rst = 1'b0; mem_resp = 1'b0; mem_rdata = '0;
    i_address = '0; d_address = '0; d_wdata = '0;
    model_reset();
    repeat (2) @(negedge clk);

    // Reset state
    quiet("reset");
    chk1("reset_conflict", arb_conflict, 1'b0);
    chka("reset_mem_address", mem_address, 32'h0);
    chkl("reset_mem_wdata", mem_wdata, '0);
    chkl("reset_i_rdata", i_rdata, '0);
    chkl("reset_d_rdata", d_rdata, '0);
    rst = 1'b1;

    // icache-only read of 0x60 with a 4-cycle adaptor
    round(1'b1, 32'h60, 1'b0, 1'b0, 1'b0, '0, '0, 4, {32{8'hA5}}, won);
    chk1("icache_only_won", won, 1'b1);

    // Simultaneous icache read and dcache writeback: write first, then icache
    round(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h200, 256'h1234, 3, rand_line(), won);
    chk1("simul_first_d", won, 1'b0);
    round(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 2, rand_line(), won);
    chk1("simul_then_i", won, 1'b1);

    idle_with_resp(2);

    // Starvation: dcache keeps asking while icache waits
    seq = '0;
    for (int r = 0; r < 6; r++) begin
      round(1'b1, 32'h400, 1'b1, 1'b1, 1'b0, 32'h800 + r * 32, rand_line(), 2, rand_line(), won);
      seq[r] = won;
    end
    chka("starve_order", seq, 32'h10);
    round(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1, rand_line(), won);
    chk1("starve_tail_i", won, 1'b1);

    // d_read and d_write together: writeback, then a second grant for the fill
    round(1'b0, '0, 1'b1, 1'b1, 1'b1, 32'h500, rand_line(), 2, rand_line(), won);
    chk1("dboth_write_d", won, 1'b0);
    round(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 3, rand_line(), won);
    chk1("dboth_read_d", won, 1'b0);

    // Unaligned icache address is line-aligned on the memory side
    round(1'b1, 32'h67, 1'b0, 1'b0, 1'b0, '0, '0, 1, rand_line(), won);
    idle_with_resp(1);

    // Reset in the middle of a dcache read
    d_read = 1'b1; d_address = 32'h300;
    @(negedge clk);
    chk1("rstmid_grant", mem_read, 1'b1);
    chka("rstmid_addr", mem_address, 32'h300);
    #2 rst = 1'b0;
    #1;
    chk1("rstmid_async_rd", mem_read, 1'b0);
    chk1("rstmid_d_resp", d_resp, 1'b0);
    chka("rstmid_addr0", mem_address, 32'h0);
    chkl("rstmid_d_rdata", d_rdata, '0);
    chkl("rstmid_i_rdata", i_rdata, '0);
    model_reset();
    @(negedge clk);
    mem_resp = 1'b1; mem_rdata = rand_line();
    @(negedge clk);
    mem_resp = 1'b0;
    chk1("rstmid_no_resp", d_resp, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      quiet("post_rst");
    end
    round(1'b0, '0, 1'b1, 1'b1, 1'b0, 32'h340, '0, 2, rand_line(), won);
    chk1("post_rst_d", won, 1'b0);

    // Random traffic
    for (int r = 0; r < 40; r++) begin
      ni = ($urandom_range(0, 1) == 1);
      nd = ($urandom_range(0, 1) == 1);
      kind = int'($urandom_range(0, 2));
      if (!i_pend && !d_pend && !ni && !nd) ni = 1'b1;
      round(ni, $urandom, nd, kind != 1, kind != 0, $urandom, rand_line(),
            int'($urandom_range(1, 5)), rand_line(), won);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single cacheline-level physical memory port between the instruction cache and the data cache.
- Sits between icache/dcache and the cacheline adaptor inside the mp4 top level.
- Grants one 256-bit line transaction at a time and routes the response back to the granted cache.
- Uses fixed dcache priority plus an anti-starvation counter for the icache.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cacheline width in bits.
- MAX_SKIP, 4, number of consecutive dcache grants made while icache is waiting, after which icache is forced next.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_read  in  1  icache line read request; held until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  returned line for icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line read request; held until d_resp.
- d_write  in  1  dcache line writeback request; held until d_resp.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache writeback data.
- d_rdata  out  LINE_W  returned line for dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- mem_read  out  1  read request to cacheline adaptor.
- mem_write  out  1  write request to cacheline adaptor.
- mem_address  out  ADDR_W  line address, low 5 bits forced to 0.
- mem_wdata  out  LINE_W  write data.
- mem_rdata  in  LINE_W  line from adaptor.
- mem_resp  in  1  adaptor completion pulse.
- arb_conflict  out  1  pulse: both caches requesting in the cycle a grant is made (perf counter hook).

Behaviour:
- States: IDLE, I_READ, D_READ, D_WRITE, DONE.
- Reset (rst=0, any time, including mid-transaction):
  - state goes to IDLE; skip counter is cleared.
  - mem_read, mem_write, i_resp, d_resp and arb_conflict are 0.
  - mem_address, mem_wdata, i_rdata and d_rdata are 0.
  - Any in-flight transaction is abandoned; the adaptor is reset by the same rst.
- IDLE, grant decision (registered; the transaction starts the next cycle):
  - Only icache requesting → I_READ.
  - Only dcache requesting → D_WRITE if d_write, else D_READ. If d_read and d_write are both 1, the write wins: a writeback precedes its fill.
  - Both requesting and skip counter < MAX_SKIP → dcache wins; counter increments and arb_conflict pulses.
  - Both requesting and skip counter == MAX_SKIP → icache wins; counter clears and arb_conflict pulses.
  - Counter also clears whenever icache is granted, or when i_read is low in IDLE.
- Address and data latching:
  - mem_address and mem_wdata are latched from the winner at grant and held constant for the whole transaction.
  - Requester changes after grant are ignored.
- I_READ / D_READ:
  - mem_read=1 until mem_resp.
  - On mem_resp: mem_rdata is latched into i_rdata/d_rdata; i_resp/d_resp pulses the same cycle (rdata is valid in that cycle); then → DONE.
- D_WRITE:
  - mem_write=1 until mem_resp.
  - On mem_resp: d_resp pulses; then → DONE.
- DONE:
  - One bubble cycle; no grants and no mem requests, so the requester can drop its request without being re-granted.
  - → IDLE.
- mem_read and mem_write are never both 1. Exactly one resp pulse is produced per granted transaction.
- i_rdata and d_rdata hold their last value until the next response to that cache.
- mem_resp arriving in IDLE or DONE is ignored.
- Minimum latency, request to resp: 1 grant cycle + adaptor latency. Back-to-back transactions are separated by 1 DONE cycle.

Decomposition:
- ooo_types package: add arb_state_t enum (IDLE, I_READ, D_READ, D_WRITE, DONE) and the LINE_W/ADDR_W constants shared with the caches and the adaptor.
- Single module. No sub-module is needed; the grant logic is combinational within the same file.

Test Plan:
- icache-only read of 0x60: i_read with i_address=0x60 → mem_read 1 cycle later with mem_address=0x60; adaptor returns 0xA5..A5 after 4 cycles → i_resp pulse with i_rdata=0xA5..A5; d_resp stays 0.
- Simultaneous requests: i_read (0x100) and d_write (0x200, wdata 0x1234) together → dcache write first with mem_write=1 and mem_wdata=0x1234; arb_conflict pulses; after d_resp and the DONE cycle, icache read of 0x100 is granted.
- Starvation: d_read re-asserted continuously while i_read is held → exactly MAX_SKIP=4 dcache grants, then an icache grant, then the counter is cleared.
- d_read and d_write both high → write granted first; the read completes only after a second grant.
- Unaligned i_address=0x67 → mem_address=0x60.
- Reset mid-transaction: rst=0 during D_READ before mem_resp → mem_read drops asynchronously and no d_resp occurs; after release, a new d_read is granted normally.
